// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch sequencer.
package fetch_pkg;

    localparam int          WORDSIZE_DEF  = 32;
    localparam logic [31:0] RESET_VEC_DEF = 32'h0000_0000;
    localparam logic [31:0] TRAP_VEC_DEF  = 32'h0000_0100;
    localparam int          INST_STEP     = 4;

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        WAIT,
        DRAIN,
        HOLD
    } state_t;

    typedef enum logic [1:0] {
        NPC_HOLD,
        NPC_INC,
        NPC_TGT,
        NPC_TRAP
    } npc_sel_t;

endpackage

// File: rtl/fetch_next_pc.sv
// Combinational next-pc select: hold, sequential step, redirect target or trap vector.
module fetch_next_pc
    import fetch_pkg::*;
#(
    parameter int                  WORDSIZE = WORDSIZE_DEF,
    parameter logic [WORDSIZE-1:0] TRAP_VEC = TRAP_VEC_DEF
) (
    input  logic [WORDSIZE-1:0] i_pc,
    input  logic [WORDSIZE-1:0] i_target,
    input  npc_sel_t            i_sel,
    output logic [WORDSIZE-1:0] o_next_pc
);

    always_comb begin
        // NOTE: default assigned first so no path through the case can infer a latch.
        o_next_pc = i_pc;
        case (i_sel)
            NPC_INC:  o_next_pc = i_pc + WORDSIZE'(INST_STEP);
            // Targets are always word aligned; misaligned ones are steered to NPC_TRAP when trapping is built in.
            NPC_TGT:  o_next_pc = i_target & ~WORDSIZE'(3);
            NPC_TRAP: o_next_pc = TRAP_VEC;
            default:  o_next_pc = i_pc;
        endcase
    end

endmodule

// File: rtl/fetch_ctrl.sv
// Instruction-fetch sequencer: owns the pc, runs the imem handshake, hands one instruction to decode.
// Optional misaligned-branch trap is built when MISALIGN_TRAP_EN is defined.
module fetch_ctrl
    import fetch_pkg::*;
#(
    parameter int                  WORDSIZE  = WORDSIZE_DEF,
    parameter logic [WORDSIZE-1:0] RESET_VEC = RESET_VEC_DEF,
    parameter logic [WORDSIZE-1:0] TRAP_VEC  = TRAP_VEC_DEF
) (
    input  logic                CLK,
    input  logic                reset,
    output logic                imem_req_valid,
    input  logic                imem_req_ready,
    output logic [WORDSIZE-1:0] imem_addr,
    input  logic                imem_rsp_valid,
    input  logic [WORDSIZE-1:0] imem_rsp_data,
    output logic                inst_valid,
    output logic [WORDSIZE-1:0] inst,
    output logic [WORDSIZE-1:0] inst_pc,
    input  logic                stall,
    input  logic                br_taken,
`ifdef MISALIGN_TRAP_EN
    output logic                misalign_trap,
`endif
    input  logic [WORDSIZE-1:0] br_target
);

    state_t              r_state;
    logic [WORDSIZE-1:0] r_pc;
    logic                r_req_valid;
    logic                r_inst_valid;
    logic [WORDSIZE-1:0] r_inst;
    logic [WORDSIZE-1:0] r_inst_pc;
    logic                w_redirect;
    logic                w_misaligned;
    npc_sel_t            w_sel;
    logic [WORDSIZE-1:0] w_next_pc;

    assign w_redirect = br_taken && (r_state != IDLE);

`ifdef MISALIGN_TRAP_EN
    logic r_trap;
    assign w_misaligned  = |br_target[1:0];
    assign misalign_trap = r_trap;

    always_ff @(posedge CLK) begin
        if (reset) r_trap <= 1'b0;
        else       r_trap <= w_redirect && w_misaligned;
    end
`else
    assign w_misaligned = 1'b0;
`endif

    always_comb begin
        w_sel = NPC_HOLD;
        if (w_redirect)                            w_sel = w_misaligned ? NPC_TRAP : NPC_TGT;
        else if (r_state == WAIT && imem_rsp_valid) w_sel = NPC_INC;
    end

    fetch_next_pc #(
        .WORDSIZE (WORDSIZE),
        .TRAP_VEC (TRAP_VEC)
    ) u_next_pc (
        .i_pc      (r_pc),
        .i_target  (br_target),
        .i_sel     (w_sel),
        .o_next_pc (w_next_pc)
    );

    // NOTE: non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge CLK) begin
        if (reset) begin
            r_state      <= IDLE;
            r_pc         <= RESET_VEC;
            r_req_valid  <= 1'b0;
            r_inst_valid <= 1'b0;
            r_inst       <= '0;
            r_inst_pc    <= '0;
        end else begin
            r_pc        <= w_next_pc;
            r_req_valid <= 1'b0;
            case (r_state)
                IDLE: begin
                    r_state     <= REQ;
                    r_req_valid <= 1'b1;
                end
                REQ: begin
                    if (br_taken) begin
                        r_state     <= imem_req_ready ? DRAIN : REQ;
                        r_req_valid <= !imem_req_ready;
                    end else if (imem_req_ready) begin
                        r_state <= WAIT;
                    end else begin
                        r_req_valid <= 1'b1;
                    end
                end
                WAIT: begin
                    if (br_taken) begin
                        r_state     <= imem_rsp_valid ? REQ : DRAIN;
                        r_req_valid <= imem_rsp_valid;
                    end else if (imem_rsp_valid) begin
                        r_inst       <= imem_rsp_data;
                        r_inst_pc    <= r_pc;
                        r_inst_valid <= 1'b1;
                        r_state      <= HOLD;
                    end
                end
                DRAIN: begin
                    // A redirect coinciding with the stale response still retires it, avoiding a deadlock.
                    if (imem_rsp_valid) begin
                        r_state     <= REQ;
                        r_req_valid <= 1'b1;
                    end
                end
                HOLD: begin
                    if (br_taken || !stall) begin
                        r_inst_valid <= 1'b0;
                        r_state      <= REQ;
                        r_req_valid  <= 1'b1;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign imem_req_valid = r_req_valid;
    assign imem_addr      = r_pc;
    assign inst_valid     = r_inst_valid;
    assign inst           = r_inst;
    assign inst_pc        = r_inst_pc;

endmodule
